// File: rtl/uart_rx_fifo_if.sv
// Consumer-side FWFT stream of the UART receive FIFO.
// master: the FIFO drives outValid/outByte/outErr and samples outReady.
// slave:  the consumer samples outValid/outByte/outErr and drives outReady.
interface uart_rx_fifo_if;
  logic       outValid;
  logic       outReady;
  logic [7:0] outByte;
  logic       outErr;

  modport master (
    output outValid,
    output outByte,
    output outErr,
    input  outReady
  );

  modport slave (
    input  outValid,
    input  outByte,
    input  outErr,
    output outReady
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Purpose: circular FIFO capturing each rising edge of rxDone (byte rxOut) for a FWFT consumer.
// Latency: byte written at the edge that first samples rxDone high; outValid/count update in the next cycle.
// Backpressure: consumer stalls via outReady=0; when full, a new byte is dropped and overflow becomes sticky.
//
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   rxDone/rxErr     receiver byte-complete level and its framing-error flag
//   rxOut            received byte
//   outIf (master)   outValid/outReady/outByte/outErr head-of-queue stream
//   count, full      occupancy (0..DEPTH) and count==DEPTH
//   overflow         sticky lost-byte flag, cleared by clearOverflow (a set in the same cycle wins)
//   errCount         saturating count of framing-errored bytes received
// Option: define UART_RX_FIFO_ERR_TAG_EN to store errored bytes with a tag bit presented on outErr;
//   without it errored bytes are dropped and outErr is tied to 0.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rxDone,
  input  logic                    rxErr,
  input  logic [7:0]              rxOut,
  uart_rx_fifo_if.master          outIf,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    overflow,
  input  logic                    clearOverflow,
  output logic [7:0]              errCount
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
`ifdef UART_RX_FIFO_ERR_TAG_EN
  localparam int ENTRY_W = 9;
`else
  localparam int ENTRY_W = 8;
`endif

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]   wp;
  logic [CNT_W-1:0]   rp;
  logic               rxDonePrev;
  logic               rxEdge;
  logic               pushReq;
  logic               pop;
  logic               doWrite;
  logic               ovfSet;
  logic [ENTRY_W-1:0] wrEntry;
  logic [ENTRY_W-1:0] headEntry;

  // rxDone is a level that can stay high for many cycles; only its rising edge is a new byte.
  assign rxEdge = rxDone & ~rxDonePrev;

`ifdef UART_RX_FIFO_ERR_TAG_EN
  assign pushReq      = rxEdge;
  assign wrEntry      = {rxErr, rxOut};
  assign outIf.outErr = headEntry[8];
`else
  assign pushReq      = rxEdge & ~rxErr;
  assign wrEntry      = rxOut;
  assign outIf.outErr = 1'b0;
`endif

  // Pointers carry one extra wrap bit so full (DEPTH) and empty (0) are distinguishable.
  assign count          = wp - rp;
  assign full           = (count == CNT_W'(DEPTH));
  assign outIf.outValid = (count != '0);
  assign pop            = outIf.outValid & outIf.outReady;

  // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
  assign doWrite = pushReq & (~full | pop);
  assign ovfSet  = pushReq & full & ~pop;

  assign headEntry     = mem[rp[ADDR_W-1:0]];
  assign outIf.outByte = headEntry[7:0];

  always_ff @(posedge clk) begin
    if (doWrite) begin
      mem[wp[ADDR_W-1:0]] <= wrEntry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp         <= '0;
      rp         <= '0;
      rxDonePrev <= 1'b1;   // a level already high at reset release is not a new byte
      overflow   <= 1'b0;
      errCount   <= '0;
    end else begin
      rxDonePrev <= rxDone;
      if (doWrite) begin
        wp <= wp + CNT_W'(1);
      end
      if (pop) begin
        rp <= rp + CNT_W'(1);
      end
      if (ovfSet) begin
        overflow <= 1'b1;
      end else if (clearOverflow) begin
        overflow <= 1'b0;
      end
      // Counts every errored byte, stored or not.
      if (rxEdge && rxErr && (errCount != 8'hFF)) begin
        errCount <= errCount + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo against a queue-based reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
// Works in both builds of the error-tag option.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
`ifdef UART_RX_FIFO_ERR_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    rxDone;
  logic                    rxErr;
  logic [7:0]              rxOut;
  logic [$clog2(DEPTH):0]  count;
  logic                    full;
  logic                    overflow;
  logic                    clearOverflow;
  logic [7:0]              errCount;

  uart_rx_fifo_if outIf ();

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .rxDone        (rxDone),
    .rxErr         (rxErr),
    .rxOut         (rxOut),
    .outIf         (outIf),
    .count         (count),
    .full          (full),
    .overflow      (overflow),
    .clearOverflow (clearOverflow),
    .errCount      (errCount)
  );

  always #5 clk = ~clk;

  // Reference model: queue of {err, byte} entries plus flags.
  logic [8:0] q[$];
  bit         mPrev;
  bit         mOvf;
  int         mErr;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    mPrev = 1'b1;
    mOvf  = 1'b0;
    mErr  = 0;
  endtask

  // What the next rising edge does, given the inputs now applied.
  task automatic modelUpdate();
    bit edgeSeen, popSeen, wasFull, store;
    edgeSeen = rxDone && !mPrev;
    mPrev    = rxDone;
    popSeen  = (q.size() != 0) && outIf.outReady;
    wasFull  = (q.size() == DEPTH);
    store    = edgeSeen && (TAG_EN || !rxErr);
    if (edgeSeen && rxErr && mErr < 255) mErr++;
    if (popSeen) void'(q.pop_front());
    if (store && wasFull && !popSeen) begin
      mOvf = 1'b1;
    end else begin
      if (store) q.push_back({rxErr, rxOut});
      if (clearOverflow) mOvf = 1'b0;
    end
  endtask

  task automatic checkAll();
    check("count", 32'(count), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("outValid", 32'(outIf.outValid), 32'(q.size() != 0));
    check("overflow", 32'(overflow), 32'(mOvf));
    check("errCount", 32'(errCount), 32'(mErr));
    if (q.size() != 0) begin
      check("outByte", 32'(outIf.outByte), 32'(q[0][7:0]));
      check("outErr", 32'(outIf.outErr), 32'(q[0][8]));
    end
  endtask

  task automatic step(input bit d, input bit e, input logic [7:0] b, input bit rdy, input bit clr);
    rxDone          = d;
    rxErr           = e;
    rxOut           = b;
    outIf.outReady  = rdy;
    clearOverflow   = clr;
    modelUpdate();
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    reset          = 1'b1;
    rxDone         = 1'b0;
    rxErr          = 1'b0;
    rxOut          = 8'h00;
    outIf.outReady = 1'b0;
    clearOverflow  = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    check("rst.outValid", 32'(outIf.outValid), 32'd0);
    check("rst.count", 32'(count), 32'd0);
    check("rst.full", 32'(full), 32'd0);
    check("rst.overflow", 32'(overflow), 32'd0);
    check("rst.errCount", 32'(errCount), 32'd0);
    reset = 1'b0;
    step(0, 0, 8'h00, 0, 0);

    // Single byte, then one-cycle pop.
    step(1, 0, 8'h35, 0, 0);
    check("single.valid", 32'(outIf.outValid), 32'd1);
    check("single.byte", 32'(outIf.outByte), 32'h35);
    check("single.count", 32'(count), 32'd1);
    step(0, 0, 8'h00, 1, 0);
    check("single.popCount", 32'(count), 32'd0);
    check("single.popValid", 32'(outIf.outValid), 32'd0);

    // rxDone held high for 50 cycles stores one byte.
    for (int i = 0; i < 50; i++) step(1, 0, 8'h5A, 0, 0);
    check("level.count", 32'(count), 32'd1);
    step(0, 0, 8'h00, 1, 0);

    // Framing error.
    step(1, 1, 8'hA5, 0, 0);
    check("ferr.errCount", 32'(errCount), 32'd1);
    if (TAG_EN) begin
      check("ferr.outErr", 32'(outIf.outErr), 32'd1);
      check("ferr.outByte", 32'(outIf.outByte), 32'hA5);
    end else begin
      check("ferr.count", 32'(count), 32'd0);
    end
    step(0, 0, 8'h00, 1, 0);

    // Fill with 17 bytes: last is lost.
    for (int i = 0; i <= 16; i++) begin
      step(1, 0, 8'(i), 0, 0);
      step(0, 0, 8'h00, 0, 0);
    end
    check("fill.full", 32'(full), 32'd1);
    check("fill.count", 32'(count), 32'd16);
    check("fill.overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("drain.byte", 32'(outIf.outByte), 32'(i));
      step(0, 0, 8'h00, 1, 0);
    end
    check("drain.count", 32'(count), 32'd0);
    step(0, 0, 8'h00, 0, 1);
    check("clearOvf", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop across pointer wrap (40 bytes total).
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 8'(8'h40 + i), 0, 0);
      step(0, 0, 8'h00, 0, 0);
    end
    for (int i = 16; i < 40; i++) begin
      step(1, 0, 8'(8'h40 + i), 1, 0);
      check("wrap.count", 32'(count), 32'd16);
      check("wrap.overflow", 32'(overflow), 32'd0);
      step(0, 0, 8'h00, 0, 0);
    end
    for (int i = 24; i < 40; i++) begin
      check("wrap.order", 32'(outIf.outByte), 32'(8'h40 + i));
      step(0, 0, 8'h00, 1, 0);
    end

    // Asynchronous reset mid-stream with rxDone held high.
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 8'(8'h80 + i), 0, 0);
      if (i < 4) step(0, 0, 8'h00, 0, 0);
    end
    check("mid.count5", 32'(count), 32'd5);
    #2 reset = 1'b1;
    #1;
    modelReset();
    check("mid.outValid", 32'(outIf.outValid), 32'd0);
    check("mid.count", 32'(count), 32'd0);
    check("mid.full", 32'(full), 32'd0);
    check("mid.overflow", 32'(overflow), 32'd0);
    check("mid.errCount", 32'(errCount), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 0, 8'h77, 0, 0);
    check("mid.noCapture", 32'(count), 32'd0);
    step(0, 0, 8'h00, 0, 0);
    step(1, 0, 8'h99, 0, 0);
    check("mid.recapture", 32'(count), 32'd1);
    check("mid.byte", 32'(outIf.outByte), 32'h99);

    // Random: slow consumer, then fast consumer.
    for (int n = 0; n < 1500; n++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, 8'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0);
    for (int n = 0; n < 1500; n++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, 8'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    // Every edge errored: drives errCount into saturation.
    for (int n = 0; n < 600; n++)
      step(1'(n & 1), 1'b1, 8'($urandom), $urandom_range(0, 1) == 1, 1'b0);
    check("errSat", 32'(errCount), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the `Uart8` receiver. It captures each byte the receiver completes (`rxOut` qualified by `rxDone`) into a power-of-two circular FIFO. It presents the bytes to the consumer over a first-word-fall-through valid/ready port. It decouples the bursty serial receive path from a consumer that may stall, and reports overflow and framing errors.

## Interface
- `DEPTH`, 16: number of entries; power of two, ≥ 2.
- `CNT_W`, `$clog2(DEPTH)+1`: width of `count`; derived, not overridden.

- `clk`  in  1  system clock; same clock as `Uart8`.
- `reset`  in  1  asynchronous, active-high reset.
- `rxDone`  in  1  receiver byte-complete flag; may be held high for many cycles.
- `rxErr`  in  1  receiver framing error for the byte completing with `rxDone`.
- `rxOut`  in  8  received byte.
- `outValid`  out  1  head entry available.
- `outReady`  in  1  consumer accepts head this cycle.
- `outByte`  out  8  head byte; meaningful only while `outValid`.
- `outErr`  out  1  head byte carried `rxErr`. Meaningful only with `UART_RX_FIFO_ERR_TAG_EN`; otherwise constant 0.
- `count`  out  CNT_W  number of stored entries, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky: a byte was lost because the FIFO was full.
- `clearOverflow`  in  1  synchronous clear of `overflow`.
- `errCount`  out  8  saturating count of framing-errored bytes received.

## Operation
- Edge capture: register `rxDonePrev`. `push = rxDone & ~rxDonePrev`, so a byte is captured exactly once per rising edge of `rxDone`.
- `rxDonePrev` resets to 1, so an `rxDone` held high across reset release is not captured.
- `pop = outValid & outReady`.
- Storage: `DEPTH` entries, each 8 bits, or 9 bits with the error tag. Write pointer `wp` and read pointer `rp` are each CNT_W bits and wrap modulo 2·DEPTH. `count = wp - rp` (mod 2^CNT_W). Memory is addressed by the low `$clog2(DEPTH)` bits.
- Push accepted: the entry is written at `wp`, and `wp` increments.
- Pop: `rp` increments.
- Full with push and no pop: the byte is discarded, `wp` is unchanged, and `overflow` is set to 1.
- Full with push and pop in the same cycle: both proceed, `count` stays `DEPTH`, and there is no overflow.
- Empty with push: `pop` is impossible because `outValid = 0`; the push proceeds.
- `outValid = (count != 0)`. `outByte` and `outErr` come combinationally from `mem[rp]` (FWFT).
- `overflow`: a set event and `clearOverflow` in the same cycle leave it at 1 (set wins).
- `errCount` increments on every push with `rxErr = 1`, whether or not the byte is stored. It saturates at 255 and is cleared only by reset.
- Reset, asynchronous and possibly mid-stream:
  - `wp = rp = 0` and the contents are discarded.
  - `overflow = 0`, `errCount = 0`, `rxDonePrev = 1`.
- Reset values of the outputs: `outValid = 0`, `count = 0`, `full = 0`, `overflow = 0`, `errCount = 0`. `outByte` and `outErr` are don't-care while `outValid = 0`.

## Timing
- Push latency: `rxDone` first sampled high at edge k. The entry is written at edge k, and `outValid = 1` and `count` are updated after edge k (visible in cycle k+1).
- Pop: the head advances at the edge where `pop = 1`. The next entry is visible in the following cycle with no bubble.
- Back-to-back: a new push may occur on any cycle in which `rxDone` rises. At 9600 baud the pushes are ≥ 1250 clocks apart, but the block must not assume this.
- `full`, `count` and `overflow` are registered-derived, with no combinational path from `rxDone` or `outReady`.
- `outValid` has no combinational dependency on `outReady`.

## Configuration
- `UART_RX_FIFO_ERR_TAG_EN` defined:
  - Entries are 9 bits, `{rxErr, rxOut}`.
  - Errored bytes are stored, and `outErr` presents the tag alongside the head byte.
- Not defined:
  - Entries are 8 bits, and `outErr` is tied to 0.
  - Bytes with `rxErr = 1` are dropped: no push and no overflow effect. `errCount` still increments.

## Test plan
- Single byte:
  - Stimulus: `rxOut = 8'h35` with `rxDone` rising, `outReady = 0`.
  - Response: in the next cycle `outValid = 1`, `outByte = 8'h35`, `count = 1`. Raising `outReady` for one cycle returns `count = 0` and `outValid = 0`.
- Level `rxDone`: hold `rxDone` high for 50 cycles. Exactly one entry is stored (`count = 1`).
- Fill and overflow (DEPTH = 16):
  - Stimulus: push 8'h00..8'h10 (17 bytes) with `outReady = 0`.
  - Response: `full = 1`, `count = 16`, `overflow = 1`. Draining yields 8'h00..8'h0F in order, and 8'h10 is lost.
  - Then pulse `clearOverflow`: `overflow = 0`.
- Full with simultaneous push and pop: `count` stays 16, `overflow` stays 0, and the output order is preserved across pointer wrap after 40 total bytes.
- Framing error: push 8'hA5 with `rxErr = 1`.
  - With the macro: `outErr = 1`, `outByte = 8'hA5`.
  - Without the macro: `count` stays 0.
  - In both cases `errCount = 1`.
- Reset mid-stream:
  - Stimulus: with 5 entries stored, assert `reset` asynchronously between clock edges while `rxDone` is high.
  - Response: the outputs go to their reset values immediately, and no byte is captured after release until `rxDone` falls and rises again.
